oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 132 +++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma
// Purpose  : Sprite-attribute DMA engine. A CPU write to $4014 (wr_page)
//            copies 256 bytes from {page,8'h00}..{page,8'hff} to the
//            OAMDATA port with one read and one write per byte. The start
//            is aligned to a free-running parity bit, so a transfer starts
//            after one or two idle cycles.
// Ports    : clk, reset            - clock, async active-high reset
//            wr_page, page         - start strobe and source page
//            bus_req/sel/rdy       - arbiter request, grant, slave ready
//            bus_addr/we/dout/oe   - master address, write enable, write
//                                    data and data-drive enable
//            bus_din               - read data
//            busy, done            - transfer in progress, end pulse
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma #(
    parameter logic [15:0] OAMDATA = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_page,
    input  logic [7:0]  page,
    output logic        bus_req,
    input  logic        bus_sel,
    input  logic        bus_rdy,
    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_dout,
    output logic        bus_oe,
    input  logic [7:0]  bus_din,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0] r_state;
    logic       r_parity;
    logic       r_align_extra;   // one extra ALIGN cycle still owed
    logic [7:0] r_page;
    logic [7:0] r_index;
    logic [7:0] r_data;
    logic       r_busy;
    logic       r_done;

    logic       w_xfer_ok;
    logic       w_in_read;
    logic       w_in_write;

    // A bus cycle completes only on an edge where both grant and ready hold;
    // otherwise READ/WRITE simply repeat with unchanged index and data.
    assign w_xfer_ok  = bus_sel & bus_rdy;
    assign w_in_read  = (r_state == S_READ);
    assign w_in_write = (r_state == S_WRITE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_parity      <= 1'b0;
            r_align_extra <= 1'b0;
            r_page        <= 8'h00;
            r_index       <= 8'h00;
            r_data        <= 8'h00;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_page) begin
                        r_page        <= page;
                        r_index       <= 8'h00;
                        // Odd parity at the strobe costs one more align cycle.
                        r_align_extra <= r_parity;
                        r_busy        <= 1'b1;
                        r_state       <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (r_align_extra) begin
                        r_align_extra <= 1'b0;
                    end else begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_xfer_ok) begin
                        r_data  <= bus_din;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_xfer_ok) begin
                        // The index wraps to zero exactly as FIN is entered,
                        // so the wrap can never restart the copy.
                        r_index <= r_index + 8'd1;
                        r_state <= (r_index == 8'hff) ? S_FIN : S_READ;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Bus outputs decode the registered state; everything driven toward the
    // shared bus is forced low whenever this master is not granted.
    assign bus_req  = w_in_read | w_in_write;
    assign bus_addr = !bus_sel   ? 16'h0000 :
                      w_in_read  ? {r_page, r_index} :
                      w_in_write ? OAMDATA : 16'h0000;
    assign bus_we   = bus_sel & w_in_write;
    assign bus_oe   = bus_we;
    assign bus_dout = bus_we ? r_data : 8'h00;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire
